ledger_validator: RTL and testbench

Parametrised successor to the single-ledger transaction checker. Accepts one transfer frame at a time over a valid/ready handshake. Looks up sender and receiver in an internal account RAM by linear scan, allocating accounts at `INIT_BAL` on first use. Applies the transfer only if it is legal and reports a per-transaction status code. Sits between the frame parser and the downstream block/commit stage.

---
 rtl/ledger_validator.sv | 206 ++++++++++++++++++++
 tb/tb_ledger_validator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ledger_validator.sv
// Transfer validator: scans an on-chip account ledger, allocates new accounts
// on first use and applies legal transfers, reporting a status per frame.
module ledger_validator #(
  parameter int ID_W     = 48,
  parameter int BAL_W    = 24,
  parameter int AMT_W    = 22,
  parameter int DEPTH    = 16384,
  parameter int INIT_BAL = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*ID_W+31:0]  data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [2*ID_W+31:0]  data_o,
  output logic                valid_o,
  output logic [2:0]          status_o,
  output logic [31:0]         accepted_cnt_o,
  output logic [31:0]         rejected_cnt_o
);

  localparam int FW = 2*ID_W+32;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW+1;
  localparam int EW = ID_W+BAL_W;

  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_SELF  = 3'd1;
  localparam logic [2:0] ST_FULL  = 3'd2;
  localparam logic [2:0] ST_FUNDS = 3'd3;
  localparam logic [2:0] ST_OVFL  = 3'd4;

  typedef enum logic [2:0] {
    IDLE, SCAN, RESOLVE, CHECK, WR_SND, WR_RCV
  } state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_q;
  logic [AW-1:0] raddr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [EW-1:0] wdata;

  state_t           state;
  logic [FW-1:0]    frame;
  logic [CW-1:0]    count;
  logic [AW-1:0]    idx;
  logic             prime;
  logic             snd_hit;
  logic             rcv_hit;
  logic [AW-1:0]    snd_ptr;
  logic [AW-1:0]    rcv_ptr;
  logic [BAL_W-1:0] snd_bal;
  logic [BAL_W-1:0] rcv_bal;
  logic [1:0]       n_new;
  logic             full;

  logic [ID_W-1:0]  snd;
  logic [ID_W-1:0]  rcv;
  logic [BAL_W-1:0] amt_ext;
  logic [ID_W-1:0]  rd_id;
  logic [BAL_W-1:0] rd_bal;
  logic             snd_m;
  logic             rcv_m;
  logic             last;
  logic             self_tx;
  logic [1:0]       n_c;
  logic [BAL_W:0]   rcv_sum;
  logic [2:0]       status_c;

  assign snd     = frame[FW-1 -: ID_W];
  assign rcv     = frame[ID_W+31 -: ID_W];
  assign amt_ext = BAL_W'(frame[AMT_W+9:10]);
  assign rd_id   = rd_q[EW-1 -: ID_W];
  assign rd_bal  = rd_q[BAL_W-1:0];
  assign snd_m   = !snd_hit && (rd_id == snd);
  assign rcv_m   = !rcv_hit && (rd_id == rcv);
  assign last    = ({1'b0, idx} == count - 1'b1);
  assign self_tx = (snd == rcv);
  assign n_c     = self_tx ? {1'b0, !snd_hit}
                           : 2'(!snd_hit) + 2'(!rcv_hit);
  assign rcv_sum = {1'b0, rcv_bal} + {1'b0, amt_ext};

  always_comb begin
    status_c = ST_OK;
    if (self_tx)                 status_c = ST_SELF;
    else if (full)               status_c = ST_FULL;
    else if (amt_ext > snd_bal)  status_c = ST_FUNDS;
    else if (rcv_sum[BAL_W])     status_c = ST_OVFL;
  end

  assign we    = (state == WR_SND) || (state == WR_RCV);
  assign waddr = (state == WR_SND) ? snd_ptr : rcv_ptr;
  assign wdata = (state == WR_SND) ? {snd, snd_bal} : {rcv, rcv_bal};

  // Ledger storage is not reset; count alone defines the live region.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ready_o        <= 1'b0;
      valid_o        <= 1'b0;
      status_o       <= '0;
      data_o         <= '0;
      accepted_cnt_o <= '0;
      rejected_cnt_o <= '0;
      frame          <= '0;
      count          <= '0;
      raddr          <= '0;
      idx            <= '0;
      prime          <= 1'b0;
      snd_hit        <= 1'b0;
      rcv_hit        <= 1'b0;
      snd_ptr        <= '0;
      rcv_ptr        <= '0;
      snd_bal        <= '0;
      rcv_bal        <= '0;
      n_new          <= '0;
      full           <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ready_o && valid_i) begin
            frame   <= data_i;
            ready_o <= 1'b0;
            if (data_i[9]) count <= '0;
            raddr   <= '0;
            idx     <= '0;
            prime   <= 1'b1;
            snd_hit <= 1'b0;
            rcv_hit <= 1'b0;
            state   <= SCAN;
          end else begin
            ready_o <= 1'b1;
          end
        end
        SCAN: begin
          // First cycle only primes the read pipeline.
          if (prime) begin
            prime <= 1'b0;
            if (count == '0) state <= RESOLVE;
            else             raddr <= raddr + 1'b1;
          end else begin
            if (snd_m) begin
              snd_hit <= 1'b1;
              snd_ptr <= idx;
              snd_bal <= rd_bal;
            end
            if (rcv_m) begin
              rcv_hit <= 1'b1;
              rcv_ptr <= idx;
              rcv_bal <= rd_bal;
            end
            if (((snd_hit || snd_m) && (rcv_hit || rcv_m)) || last) begin
              state <= RESOLVE;
            end else begin
              idx   <= idx + 1'b1;
              raddr <= raddr + 1'b1;
            end
          end
        end
        RESOLVE: begin
          n_new <= n_c;
          full  <= (count + CW'(n_c)) > CW'(DEPTH);
          if (!snd_hit) begin
            snd_ptr <= count[AW-1:0];
            snd_bal <= BAL_W'(INIT_BAL);
          end
          if (!rcv_hit) begin
            rcv_ptr <= AW'(count + CW'(!snd_hit));
            rcv_bal <= BAL_W'(INIT_BAL);
          end
          state <= CHECK;
        end
        CHECK: begin
          valid_o  <= 1'b1;
          status_o <= status_c;
          data_o   <= frame;
          if (status_c == ST_OK) begin
            snd_bal        <= snd_bal - amt_ext;
            rcv_bal        <= rcv_sum[BAL_W-1:0];
            count          <= count + CW'(n_new);
            accepted_cnt_o <= accepted_cnt_o + 32'd1;
            state          <= WR_SND;
          end else begin
            rejected_cnt_o <= rejected_cnt_o + 32'd1;
            ready_o        <= 1'b1;
            state          <= IDLE;
          end
        end
        WR_SND: state <= WR_RCV;
        WR_RCV: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ledger_validator.sv
// Directed scoreboard bench for ledger_validator on a small ledger
// (4 entries, 8-bit balances) so FULL and OVFL are reachable.
module tb_ledger_validator;

  localparam int ID_W     = 48;
  localparam int BAL_W    = 8;
  localparam int AMT_W    = 8;
  localparam int DEPTH    = 4;
  localparam int INIT_BAL = 100;
  localparam int FW       = 2*ID_W+32;
  localparam int BAL_MAX  = (1 << BAL_W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [FW-1:0] data_o;
  logic          valid_o;
  logic [2:0]    status_o;
  logic [31:0]   acc_o;
  logic [31:0]   rej_o;

  ledger_validator #(
    .ID_W(ID_W), .BAL_W(BAL_W), .AMT_W(AMT_W),
    .DEPTH(DEPTH), .INIT_BAL(INIT_BAL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .valid_o(valid_o),
    .status_o(status_o),
    .accepted_cnt_o(acc_o),
    .rejected_cnt_o(rej_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    st;
    logic [FW-1:0] data;
    logic [31:0]   acc;
    logic [31:0]   rej;
    int            k;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int pulses = 0;

  logic [ID_W-1:0] m_id [DEPTH];
  int m_bal [DEPTH];
  int m_cnt = 0;
  int m_acc = 0;
  int m_rej = 0;
  int m_tx  = 0;

  localparam logic [ID_W-1:0] A = 48'hA0A0_0000_0001;
  localparam logic [ID_W-1:0] B = 48'hB0B0_0000_0002;
  localparam logic [ID_W-1:0] C = 48'hC0C0_0000_0003;
  localparam logic [ID_W-1:0] D = 48'hD0D0_0000_0004;
  localparam logic [ID_W-1:0] E = 48'hE0E0_0000_0005;

  always @(negedge clk) if (valid_o) pulses++;

  task automatic chk(input string tag, input logic [FW-1:0] got,
                     input logic [FW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [ID_W-1:0] s,
                                       input logic [ID_W-1:0] r,
                                       input int amt, input bit bs);
    logic [31:0] w;
    w = $urandom;
    w[AMT_W+9:10] = amt[AMT_W-1:0];
    w[9] = bs;
    return {s, r, w};
  endfunction

  task automatic wait_ready();
    int cyc;
    @(negedge clk);
    cyc = 0;
    while (!ready_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_wait", ready_o, 1);
  endtask

  task automatic send(input logic [ID_W-1:0] s, input logic [ID_W-1:0] r,
                      input int amt, input bit bs);
    exp_t e;
    int si, ri, n, sbal, rbal, cyc;
    bit self_tx, seen;
    logic [FW-1:0] f;
    f = mk(s, r, amt, bs);
    if (bs) m_cnt = 0;
    si = -1;
    ri = -1;
    for (int i = 0; i < m_cnt; i++) begin
      if (m_id[i] == s) si = i;
      if (m_id[i] == r) ri = i;
    end
    self_tx = (s == r);
    e.k = (si >= 0 && ri >= 0) ? ((si > ri ? si : ri) + 1) : m_cnt;
    n = self_tx ? int'(si < 0) : int'(si < 0) + int'(ri < 0);
    sbal = (si >= 0) ? m_bal[si] : INIT_BAL;
    rbal = (ri >= 0) ? m_bal[ri] : INIT_BAL;
    if (self_tx)                 e.st = 3'd1;
    else if (m_cnt + n > DEPTH)  e.st = 3'd2;
    else if (amt > sbal)         e.st = 3'd3;
    else if (rbal + amt > BAL_MAX) e.st = 3'd4;
    else                         e.st = 3'd0;
    if (e.st == 3'd0) begin
      if (si < 0) begin si = m_cnt; m_id[si] = s; m_cnt++; end
      if (ri < 0) begin ri = m_cnt; m_id[ri] = r; m_cnt++; end
      m_bal[si] = sbal - amt;
      m_bal[ri] = rbal + amt;
      m_acc++;
    end else begin
      m_rej++;
    end
    e.data = f;
    e.acc = m_acc;
    e.rej = m_rej;
    sb.push_back(e);
    m_tx++;

    wait_ready();
    data_i = f;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      seen = valid_o;
    end
    e = sb.pop_front();
    chk("valid_seen", seen, 1);
    chk("latency", cyc, e.k + 3);
    chk("status", status_o, e.st);
    chk("data_echo", data_o, e.data);
    chk("accepted", acc_o, e.acc);
    chk("rejected", rej_o, e.rej);
    chk("ready_at_out", ready_o, e.st != 3'd0);
    chk("count", dut.count, m_cnt);
    @(posedge clk);
    #1;
    chk("valid_pulse", valid_o, 0);
    if (e.st == 3'd0) begin
      chk("ready_during_wr", ready_o, 0);
      @(posedge clk);
      #1;
      chk("ready_after_wr", ready_o, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [FW-1:0] f;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_status", status_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_acc", acc_o, 0);
    chk("rst_rej", rej_o, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_release_ready", ready_o, 1);

    send(A, B, 30, 1'b1);
    send(B, A, 131, 1'b0);
    send(B, A, 130, 1'b0);
    send(C, C, 5, 1'b0);
    send(C, D, 0, 1'b0);
    send(E, A, 1, 1'b0);
    send(A, C, 10, 1'b0);
    send(A, D, 150, 1'b0);
    send(C, D, 6, 1'b0);
    send(C, D, 5, 1'b0);
    send(C, D, 106, 1'b0);
    send(A, B, 30, 1'b1);
    send(B, A, 131, 1'b0);
    send(A, B, 71, 1'b0);

    // Reset while the DUT is scanning; the frame must vanish silently.
    f = mk(A, B, 1, 1'b0);
    wait_ready();
    data_i = f;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(posedge clk);
    #1;
    p0 = pulses;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_acc", acc_o, 0);
    chk("mid_rst_rej", rej_o, 0);
    chk("mid_rst_count", dut.count, 0);
    repeat (3) @(posedge clk);
    #1 chk("mid_rst_ready_hold", ready_o, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_status", status_o, 0);
    chk("post_rst_data", data_o, 0);
    repeat (6) @(posedge clk);
    #1 chk("no_lost_pulse", pulses, p0);
    m_cnt = 0;
    m_acc = 0;
    m_rej = 0;

    send(A, B, 30, 1'b0);
    send(B, A, 131, 1'b0);

    chk("pulse_total", pulses, m_tx);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
